gpio_bus_arb: RTL and testbench

Two-requester arbiter and sequencer for the GPIO peripheral local bus. It sits in front of the GPIO top block and shares its single `sel/addr/we/wdata/rdata` port between the core load/store path (requester 0) and an auxiliary master such as debug or DMA (requester 1). Each accepted request becomes exactly one registered bus cycle. The block waits a fixed read latency, captures read data and returns a one-cycle acknowledge to the winner. Ties are resolved by round-robin.

---
 rtl/gpio_bus_arb.sv | 158 +++++++++++++++
 tb/tb_gpio_bus_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_arb.sv
// Two-requester round-robin arbiter and sequencer for the GPIO local bus.
// Each grant becomes one registered bus cycle, then a fixed read latency, then a one-cycle ack.
module gpio_bus_arb #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [2:0]        we0,
  input  logic [2:0]        we1,
  input  logic [XLEN-1:0]   wdata0,
  input  logic [XLEN-1:0]   wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [XLEN-1:0]   rdata0,
  output logic [XLEN-1:0]   rdata1,
  output logic              sel,
  output logic [AWIDTH-1:0] addr,
  output logic [2:0]        we,
  output logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // WAIT is skipped entirely when the latency is a single cycle.
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic [2:0]        we_lat_q, we_lat_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [2:0]        we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d;
  logic              grant1;
  logic              enter_resp;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    we_lat_d   = we_lat_q;
    cnt_d      = cnt_q;
    sel_d      = 1'b0;
    addr_d     = addr_q;
    we_d       = 3'd0;
    wdata_d    = wdata_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    enter_resp = 1'b0;
    // On a tie the requester that was not granted last time wins.
    grant1     = req1 & (~req0 | ~last_q);

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d  = S_ISSUE;
          win_d    = grant1;
          last_d   = grant1;
          sel_d    = 1'b1;
          addr_d   = grant1 ? addr1 : addr0;
          we_d     = grant1 ? we1 : we0;
          wdata_d  = grant1 ? wdata1 : wdata0;
          we_lat_d = grant1 ? we1 : we0;
        end
      end
      S_ISSUE: begin
        if (RD_LAT <= 1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus read data is captured on the same edge that raises the ack.
    if (enter_resp) begin
      ack0_d = ~win_q;
      ack1_d = win_q;
      if (we_lat_q == 3'd0) begin
        if (win_q) rdata1_d = rdata;
        else       rdata0_d = rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      we_lat_q <= 3'd0;
      cnt_q    <= 2'd0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 3'd0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_lat_q <= we_lat_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign sel    = sel_q;
  assign addr   = addr_q;
  assign we     = we_q;
  assign wdata  = wdata_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Directed bench for gpio_bus_arb: three instances (read latency 1, 3 and 4) share
// the stimulus; each scenario checks only the instance whose latency it targets.
module tb_gpio_bus_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [7:0]  addr0, addr1;
   logic [2:0]  we0, we1;
   logic [31:0] wdata0, wdata1;
   logic [31:0] busRdata;

   // Index 0: RD_LAT=1, index 1: RD_LAT=3, index 2: RD_LAT=4
   logic        selO[3];
   logic [7:0]  addrO[3];
   logic [2:0]  weO[3];
   logic [31:0] wdataO[3];
   logic        ack0O[3];
   logic        ack1O[3];
   logic [31:0] rdata0O[3];
   logic [31:0] rdata1O[3];

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   gpio_bus_arb #(.XLEN(32), .AWIDTH(8), .RD_LAT(1)) uLat1 (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0O[0]), .ack1(ack1O[0]), .rdata0(rdata0O[0]), .rdata1(rdata1O[0]),
      .sel(selO[0]), .addr(addrO[0]), .we(weO[0]), .wdata(wdataO[0]), .rdata(busRdata));

   gpio_bus_arb #(.XLEN(32), .AWIDTH(8), .RD_LAT(3)) uLat3 (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0O[1]), .ack1(ack1O[1]), .rdata0(rdata0O[1]), .rdata1(rdata1O[1]),
      .sel(selO[1]), .addr(addrO[1]), .we(weO[1]), .wdata(wdataO[1]), .rdata(busRdata));

   gpio_bus_arb #(.XLEN(32), .AWIDTH(8), .RD_LAT(4)) uLat4 (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1),
      .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0O[2]), .ack1(ack1O[2]), .rdata0(rdata0O[2]), .rdata1(rdata1O[2]),
      .sel(selO[2]), .addr(addrO[2]), .we(weO[2]), .wdata(wdataO[2]), .rdata(busRdata));

   // Single comparison point: counts every check and reports any disagreement
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      else
         passCount++;
   endtask

   // Drives the request-side inputs of both requesters at once
   task automatic applyStimulus(input logic r0, input logic [7:0] a0, input logic [2:0] w0, input logic [31:0] d0,
                                input logic r1, input logic [7:0] a1, input logic [2:0] w1, input logic [31:0] d1);
      req0 = r0; addr0 = a0; we0 = w0; wdata0 = d0;
      req1 = r1; addr1 = a1; we1 = w1; wdata1 = d1;
   endtask

   // Inputs change and outputs are sampled on the falling edge, away from the active edge
   task automatic tick();
      @(negedge clk);
   endtask

   // Holds reset for two cycles with the given stimulus already applied, then releases it
   task automatic resetAll();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Every output of one instance must read zero
   task automatic checkAllZero(input int idx, input string tag);
      checkOutput({tag, ".sel"},    64'(selO[idx]),    64'd0);
      checkOutput({tag, ".addr"},   64'(addrO[idx]),   64'd0);
      checkOutput({tag, ".we"},     64'(weO[idx]),     64'd0);
      checkOutput({tag, ".wdata"},  64'(wdataO[idx]),  64'd0);
      checkOutput({tag, ".ack0"},   64'(ack0O[idx]),   64'd0);
      checkOutput({tag, ".ack1"},   64'(ack1O[idx]),   64'd0);
      checkOutput({tag, ".rdata0"}, 64'(rdata0O[idx]), 64'd0);
      checkOutput({tag, ".rdata1"}, 64'(rdata1O[idx]), 64'd0);
   endtask

   initial begin
      busRdata = 32'h0;
      applyStimulus(1'b0, 8'h00, 3'd0, 32'h0, 1'b0, 8'h00, 3'd0, 32'h0);

      // Reset state and first read from requester 0 (RD_LAT=1)
      $display("[TB] reset and first read");
      resetAll();
      checkAllZero(0, "rst");
      busRdata = 32'h0000_1A5C;
      applyStimulus(1'b1, 8'h04, 3'd0, 32'h0, 1'b0, 8'h00, 3'd0, 32'h0);
      tick();
      checkOutput("rd.sel",  64'(selO[0]),  64'd1);
      checkOutput("rd.addr", 64'(addrO[0]), 64'h04);
      checkOutput("rd.ack0early", 64'(ack0O[0]), 64'd0);
      tick();
      checkOutput("rd.selLow", 64'(selO[0]),    64'd0);
      checkOutput("rd.ack0",   64'(ack0O[0]),   64'd1);
      checkOutput("rd.rdata0", 64'(rdata0O[0]), 64'h1A5C);
      checkOutput("rd.rdata1", 64'(rdata1O[0]), 64'd0);
      req0 = 1'b0;
      tick();
      checkOutput("rd.ack0once", 64'(ack0O[0]), 64'd0);
      tick();

      // Write from requester 1; bus read data must not leak into rdata1
      $display("[TB] write from requester 1");
      busRdata = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 8'h00, 3'b111, 32'hA5);
      tick();
      checkOutput("wr.sel",   64'(selO[0]),   64'd1);
      checkOutput("wr.we",    64'(weO[0]),    64'd7);
      checkOutput("wr.wdata", 64'(wdataO[0]), 64'hA5);
      checkOutput("wr.addr",  64'(addrO[0]),  64'h00);
      tick();
      checkOutput("wr.selLow", 64'(selO[0]),    64'd0);
      checkOutput("wr.weLow",  64'(weO[0]),     64'd0);
      checkOutput("wr.ack1",   64'(ack1O[0]),   64'd1);
      checkOutput("wr.ack0",   64'(ack0O[0]),   64'd0);
      checkOutput("wr.rdata1", 64'(rdata1O[0]), 64'd0);
      checkOutput("wr.rdata0", 64'(rdata0O[0]), 64'h1A5C);
      req1 = 1'b0;
      tick();
      checkOutput("wr.ack1once",  64'(ack1O[0]),  64'd0);
      checkOutput("wr.wdataHold", 64'(wdataO[0]), 64'hA5);

      // Both requests held from reset: grants alternate 0,1,0,1 every 3 cycles
      $display("[TB] simultaneous requests");
      applyStimulus(1'b1, 8'h10, 3'd0, 32'h0, 1'b1, 8'h20, 3'd0, 32'h0);
      resetAll();
      for (int i = 1; i <= 12; i++) begin
         tick();
         checkOutput($sformatf("rr.c%0d.ack", i), 64'({ack1O[0], ack0O[0]}),
                     (i == 2 || i == 8) ? 64'd1 : (i == 5 || i == 11) ? 64'd2 : 64'd0);
         checkOutput($sformatf("rr.c%0d.sel", i), 64'(selO[0]),
                     (i == 1 || i == 4 || i == 7 || i == 10) ? 64'd1 : 64'd0);
         if (i == 1 || i == 7)  checkOutput($sformatf("rr.c%0d.addr", i), 64'(addrO[0]), 64'h10);
         if (i == 4 || i == 10) checkOutput($sformatf("rr.c%0d.addr", i), 64'(addrO[0]), 64'h20);
      end

      // RD_LAT=4: only the data present at the fourth edge after sel is captured
      $display("[TB] latency 4 read");
      applyStimulus(1'b0, 8'h00, 3'd0, 32'h0, 1'b0, 8'h00, 3'd0, 32'h0);
      resetAll();
      busRdata = 32'h1111_1111;
      applyStimulus(1'b1, 8'h08, 3'd0, 32'h0, 1'b0, 8'h00, 3'd0, 32'h0);
      tick();
      checkOutput("l4.sel",  64'(selO[2]),  64'd1);
      checkOutput("l4.addr", 64'(addrO[2]), 64'h08);
      busRdata = 32'h2222_2222;
      tick();
      busRdata = 32'h3333_3333;
      checkOutput("l4.c2.ack0", 64'(ack0O[2]), 64'd0);
      tick();
      busRdata = 32'h3333_0003;
      checkOutput("l4.c3.ack0", 64'(ack0O[2]), 64'd0);
      tick();
      busRdata = 32'h4444_0004;
      checkOutput("l4.c4.ack0",   64'(ack0O[2]),   64'd0);
      checkOutput("l4.c4.rdata0", 64'(rdata0O[2]), 64'd0);
      tick();
      checkOutput("l4.ack0",   64'(ack0O[2]),   64'd1);
      checkOutput("l4.rdata0", 64'(rdata0O[2]), 64'h4444_0004);
      busRdata = 32'h5555_5555;
      req0 = 1'b0;
      tick();
      checkOutput("l4.ack0once",  64'(ack0O[2]),   64'd0);
      checkOutput("l4.rdataHold", 64'(rdata0O[2]), 64'h4444_0004);

      // Request withdrawn after one cycle still completes; req1 pulsed while busy is ignored
      $display("[TB] request withdrawal");
      applyStimulus(1'b0, 8'h00, 3'd0, 32'h0, 1'b0, 8'h00, 3'd0, 32'h0);
      resetAll();
      busRdata = 32'h77;
      applyStimulus(1'b1, 8'h0C, 3'd0, 32'h0, 1'b0, 8'h30, 3'd0, 32'h0);
      tick();
      req0 = 1'b0;
      req1 = 1'b1;
      checkOutput("wd.sel",  64'(selO[0]),  64'd1);
      checkOutput("wd.addr", 64'(addrO[0]), 64'h0C);
      tick();
      req1 = 1'b0;
      checkOutput("wd.ack0",   64'(ack0O[0]),   64'd1);
      checkOutput("wd.rdata0", 64'(rdata0O[0]), 64'h77);
      for (int i = 3; i <= 6; i++) begin
         tick();
         checkOutput($sformatf("wd.c%0d.sel", i),  64'(selO[0]),  64'd0);
         checkOutput($sformatf("wd.c%0d.ack1", i), 64'(ack1O[0]), 64'd0);
      end

      // Reset during WAIT (RD_LAT=3) aborts without an ack and restores round-robin state
      $display("[TB] reset during wait");
      applyStimulus(1'b0, 8'h00, 3'd0, 32'h0, 1'b0, 8'h00, 3'd0, 32'h0);
      resetAll();
      busRdata = 32'h99;
      applyStimulus(1'b1, 8'h14, 3'd2, 32'hCAFE, 1'b0, 8'h18, 3'd0, 32'h0);
      tick();
      checkOutput("ab.sel",   64'(selO[1]),   64'd1);
      checkOutput("ab.wdata", 64'(wdataO[1]), 64'hCAFE);
      tick();
      rst = 1'b1;
      #1;
      checkAllZero(1, "ab.async");
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("ab.r%0d.ack", i), 64'({ack1O[1], ack0O[1]}), 64'd0);
      end
      applyStimulus(1'b1, 8'h14, 3'd0, 32'h0, 1'b1, 8'h18, 3'd0, 32'h0);
      rst = 1'b0;
      tick();
      checkOutput("ab.regrantSel",  64'(selO[1]),  64'd1);
      checkOutput("ab.regrantAddr", 64'(addrO[1]), 64'h14);
      tick();
      tick();
      checkOutput("ab.c3.ack", 64'({ack1O[1], ack0O[1]}), 64'd0);
      tick();
      checkOutput("ab.c4.ack", 64'({ack1O[1], ack0O[1]}), 64'd1);
      checkOutput("ab.rdata0", 64'(rdata0O[1]), 64'h99);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
